// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed data memory. Sub-word stores are
// performed as read-modify-write; loads are extracted and sign/zero-extended.
//
// state | meaning
// IDLE  | waiting for a request, memory outputs quiet
// RD    | memory read strobe; load result or store merge captured here
// WR    | memory write strobe for one cycle
// RESP  | done_o pulse, error_o valid
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_read_en_o,
  output logic                  mem_write_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_word_q, wr_word_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    funct3_ok;
  logic                    misaligned;
  logic                    req_bad;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merge_word;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    funct3_ok = 1'b0;
    if (we_i) funct3_ok = (funct3_i <= 3'd2);
    else      funct3_ok = (funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'd1:    misaligned = addr_i[0];
      2'd2:    misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_bad = !funct3_ok || misaligned;
  end

  always_comb begin
    byte_sel = 8'h00;
    case (addr_q[1:0])
      2'd0: byte_sel = mem_rdata_i[7:0];
      2'd1: byte_sel = mem_rdata_i[15:8];
      2'd2: byte_sel = mem_rdata_i[23:16];
      2'd3: byte_sel = mem_rdata_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_val = {24'h0, byte_sel};
      3'd5:    load_val = {16'h0, half_sel};
      default: load_val = mem_rdata_i;
    endcase
  end

  // wr_word_q still holds the store data while in RD, so merge from it.
  always_comb begin
    merge_word = mem_rdata_i;
    if (funct3_q[1:0] == 2'd0) begin
      case (addr_q[1:0])
        2'd0: merge_word[7:0]   = wr_word_q[7:0];
        2'd1: merge_word[15:8]  = wr_word_q[7:0];
        2'd2: merge_word[23:16] = wr_word_q[7:0];
        2'd3: merge_word[31:24] = wr_word_q[7:0];
        default: merge_word = mem_rdata_i;
      endcase
    end else if (addr_q[1]) begin
      merge_word[31:16] = wr_word_q[15:0];
    end else begin
      merge_word[15:0] = wr_word_q[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d      = we_i;
          funct3_d  = funct3_i;
          addr_d    = addr_i;
          wr_word_d = wdata_i;
          err_d     = req_bad;
          if (req_bad)                           state_d = RESP;
          else if (we_i && funct3_i == 3'd2)     state_d = WR;
          else                                   state_d = RD;
        end
      end
      RD: begin
        if (we_q) begin
          wr_word_d = merge_word;
          state_d   = WR;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = (state_q == RESP);
    error_o        = (state_q == RESP) && err_q;
    mem_read_en_o  = (state_q == RD);
    mem_write_en_o = (state_q == WR);
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    if (state_q != IDLE) mem_addr_o = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    if (state_q == WR)   mem_wdata_o = wr_word_q;
    rdata_o        = rdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model
// (combinational read, write on the clock edge while write_en is high).
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, error;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en;
  logic        preload;

  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .we_i(we), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done),
    .error_o(error), .rdata_o(rdata), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_read_en_o(mem_read_en),
    .mem_write_en_o(mem_write_en), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (mem_write_en) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; counts cycles from the accept edge to done_o.
  task automatic run_op(input logic op_we, input logic [2:0] op_f3,
                        input logic [31:0] op_addr, input logic [31:0] op_wd,
                        input bit hold,
                        output int lat, output int rd_n, output int wr_n,
                        output int done_n, output logic [31:0] seen_addr,
                        output logic err_at_done);
    lat = -1; rd_n = 0; wr_n = 0; done_n = 0; seen_addr = 32'hFFFF_FFFF;
    err_at_done = 1'bx;
    @(negedge clk);
    req = 1'b1; we = op_we; funct3 = op_f3; addr = op_addr; wdata = op_wd;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_read_en) begin rd_n++; seen_addr = mem_addr; end
      if (mem_write_en) begin wr_n++; seen_addr = mem_addr; end
      if (done) begin
        done_n++;
        if (lat < 0) begin lat = c; err_at_done = error; end
      end
      req = (hold && lat < 0) ? 1'b1 : 1'b0;
      if (lat >= 0 && c >= lat + 2) break;
    end
    req = 1'b0;
  endtask

  int          lat, rd_n, wr_n, done_n;
  logic [31:0] seen;
  logic        err_d;
  bit          saw_wr;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'h0;
    wdata = 32'h0; preload = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset error", {31'h0, error}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset strobes", {30'h0, mem_read_en, mem_write_en}, 32'h0);
    preload = 1'b0; rst_n = 1'b1;

    run_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lw latency", 32'(lat), 32'd2);
    chk("lw rdata", rdata, 32'h8899AABB);
    chk("lw error", {31'h0, err_d}, 32'h0);
    chk("lw read_en cycles", 32'(rd_n), 32'd1);
    chk("lw write_en cycles", 32'(wr_n), 32'd0);
    chk("lw mem_addr", seen, 32'h10);

    run_op(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lb 0x13", rdata, 32'hFFFFFF88);
    chk("lb addr aligned", seen, 32'h10);
    run_op(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lbu 0x13", rdata, 32'h00000088);
    run_op(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lh 0x12", rdata, 32'hFFFF8899);
    run_op(1'b0, 3'd5, 32'h10, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lhu 0x10", rdata, 32'h0000AABB);
    run_op(1'b0, 3'd0, 32'h10, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lb 0x10", rdata, 32'hFFFFFFBB);

    run_op(1'b1, 3'd0, 32'h11, 32'h12345678, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("sb latency", 32'(lat), 32'd3);
    chk("sb write_en cycles", 32'(wr_n), 32'd1);
    chk("sb read_en cycles", 32'(rd_n), 32'd1);
    chk("sb merged word", mem[4], 32'h889978BB);
    chk("sb rdata held", rdata, 32'hFFFFFFBB);
    run_op(1'b1, 3'd1, 32'h12, 32'h0000CAFE, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("sh merged word", mem[4], 32'hCAFE78BB);
    chk("sh error", {31'h0, err_d}, 32'h0);

    run_op(1'b1, 3'd2, 32'h14, 32'hDEADBEEF, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("sw latency", 32'(lat), 32'd2);
    chk("sw no read", 32'(rd_n), 32'd0);
    chk("sw word", mem[5], 32'hDEADBEEF);
    chk("sw neighbour", mem[4], 32'hCAFE78BB);

    run_op(1'b0, 3'd2, 32'h12, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lw mis latency", 32'(lat), 32'd1);
    chk("lw mis error", {31'h0, err_d}, 32'h1);
    chk("lw mis strobes", 32'(rd_n + wr_n), 32'd0);
    chk("lw mis rdata held", rdata, 32'hFFFFFFBB);
    run_op(1'b0, 3'd1, 32'h11, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("lh mis latency", 32'(lat), 32'd1);
    chk("lh mis error", {31'h0, err_d}, 32'h1);
    chk("lh mis strobes", 32'(rd_n + wr_n), 32'd0);
    run_op(1'b0, 3'd3, 32'h10, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("load f3=3 error", {31'h0, err_d}, 32'h1);
    chk("load f3=3 strobes", 32'(rd_n + wr_n), 32'd0);
    run_op(1'b1, 3'd4, 32'h10, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("store f3=4 error", {31'h0, err_d}, 32'h1);
    chk("store f3=4 word", mem[4], 32'hCAFE78BB);
    run_op(1'b1, 3'd2, 32'h16, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("sw mis error", {31'h0, err_d}, 32'h1);
    chk("sw mis word", mem[5], 32'hDEADBEEF);

    run_op(1'b1, 3'd0, 32'h10, 32'h000000AA, 1'b1, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("busy req done count", 32'(done_n), 32'd1);
    chk("busy req latency", 32'(lat), 32'd3);
    chk("busy req write count", 32'(wr_n), 32'd1);
    chk("busy req word", mem[4], 32'hCAFE78AA);

    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h10; wdata = 32'h00000055;
    @(posedge clk);
    saw_wr = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (mem_write_en) begin saw_wr = 1'b1; break; end
    end
    chk("rst reached WR", {31'h0, saw_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst write_en drop", {31'h0, mem_write_en}, 32'h0);
    chk("rst busy drop", {31'h0, busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst word unchanged", mem[4], 32'hCAFE78AA);
    chk("rst rdata cleared", rdata, 32'h0);
    run_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, lat, rd_n, wr_n, done_n, seen, err_d);
    chk("post rst lw", rdata, 32'hCAFE78AA);
    chk("post rst lw latency", 32'(lat), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
